program_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a program as a byte stream and writes 16-bit instruction words into instruction memory.
- Holds the calculator core in reset while loading; releases it only after a complete, checksum-verified image.
- Sits between a byte source (serial receiver, valid/ready) and the instruction memory write port, beside the Calculator top.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/program_loader_xor_checksum.sv | 25 ++
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package prog_loader_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CHK  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/program_loader_xor_checksum.sv
// Byte-wide XOR accumulator with synchronous clear and enable.
module xor_checksum
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [BYTE_W-1:0] i_data,
   output logic [BYTE_W-1:0] o_sum
);

   logic [BYTE_W-1:0] r_sum;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum ^ i_data;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes 16-bit words
// into instruction memory, holding the core in reset until the image verifies.
module program_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic [1:0]        err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

   state_t              r_state;
   logic [BYTE_W-1:0]   r_hi;
   logic [15:0]         r_len;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W:0]     r_words;
   logic [1:0]          r_err;

   logic                w_xfer;
   logic                w_idle_like;
   logic [15:0]         w_len;
   logic [BYTE_W-1:0]   w_sum;

   assign in_ready    = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                        (r_state == DATA_HI) || (r_state == DATA_LO) ||
                        (r_state == CHECK);
   assign w_xfer      = in_valid && in_ready;
   assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
   assign w_len       = {r_hi, in_data};

   xor_checksum u_chk (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (start && w_idle_like),
      .i_en   (w_xfer && (r_state != CHECK)),
      .i_data (in_data),
      .o_sum  (w_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_hi    <= '0;
         r_len   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_words <= '0;
         r_err   <= ERR_NONE;
      end else begin
         r_we <= 1'b0;
         // Address and count advance on the cycle the write strobe is visible.
         if (r_we) begin
            r_addr  <= r_addr + 1'b1;
            r_words <= r_words + 1'b1;
         end
         case (r_state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  r_state <= LEN_HI;
                  r_addr  <= '0;
                  r_words <= '0;
                  r_err   <= ERR_NONE;
               end
            end
            LEN_HI: begin
               if (w_xfer) begin
                  r_hi    <= in_data;
                  r_state <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (w_xfer) begin
                  r_len <= w_len;
                  if (32'(w_len) > MAX_WORDS) begin
                     r_state <= ERR;
                     r_err   <= ERR_LEN;
                  end else if (w_len == 16'd0) begin
                     r_state <= CHECK;
                  end else begin
                     r_state <= DATA_HI;
                  end
               end
            end
            DATA_HI: begin
               if (w_xfer) begin
                  r_hi    <= in_data;
                  r_state <= DATA_LO;
               end
            end
            DATA_LO: begin
               if (w_xfer) begin
                  r_we    <= 1'b1;
                  r_wdata <= {r_hi, in_data};
                  r_state <= ((32'(r_words) + 32'd1) == 32'(r_len)) ? CHECK : DATA_HI;
               end
            end
            CHECK: begin
               if (w_xfer) begin
                  if (in_data == w_sum) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= ERR;
                     r_err   <= ERR_CHK;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign im_we        = r_we;
   assign im_addr      = r_addr;
   assign im_wdata     = r_wdata;
   assign cpu_rst      = (r_state != DONE);
   assign done         = (r_state == DONE);
   assign err          = r_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes, a monitor checks them.
module tb_program_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [15:0] im_wdata;
   logic        cpu_rst;
   logic        done;
   logic [1:0]  err;
   logic [10:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [25:0] sb[$];
   logic [15:0] words[1024];

   program_loader #(.ADDR_W(10), .DATA_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Monitor: every write strobe must match the oldest expected write.
   initial begin
      logic [25:0] exp_w;
      forever begin
         @(negedge clk);
         if (im_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h", im_addr, im_wdata);
            end else begin
               exp_w = sb.pop_front();
               if ({im_addr, im_wdata} !== exp_w) begin
                  errors++;
                  $display("FAIL write got addr=%0h data=%0h want addr=%0h data=%0h",
                           im_addr, im_wdata, exp_w[25:16], exp_w[15:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit do_start, input bit do_rst);
      int tmo;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      tmo = 0;
      forever begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = b;
         if (in_ready === 1'b1) begin
            start = do_start;
            rst   = do_rst;
            break;
         end
         tmo++;
         if (tmo > 100) begin
            errors++;
            $display("FAIL in_ready_timeout byte=%0h", b);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic send_frame(input int n, input int gap_max, input bit bad_chk,
                             input int start_at, input int rst_at);
      logic [7:0]  c;
      logic [7:0]  b;
      logic [15:0] w;
      logic [9:0]  a;
      int          last;
      int          gap;
      c    = 8'h00;
      last = 2 * n + 2;
      for (int idx = 0; idx <= last; idx++) begin
         w = words[(idx >= 2 && idx < last) ? (idx - 2) / 2 : 0];
         if (idx == 0)         b = n[15:8];
         else if (idx == 1)    b = n[7:0];
         else if (idx == last) b = bad_chk ? 8'h00 : c;
         else if (idx % 2 == 0) b = w[15:8];
         else                  b = w[7:0];
         if (idx != last) c = c ^ b;
         if (idx >= 3 && idx < last && (idx % 2 == 1) && idx != rst_at) begin
            a = 10'((idx - 3) / 2);
            sb.push_back({a, w});
         end
         gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         send_byte(b, gap, idx == start_at, idx == rst_at);
         if (idx == rst_at) return;
      end
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_im_we"}, im_we, 0);
      chk({tag, "_im_addr"}, im_addr, 0);
      chk({tag, "_im_wdata"}, im_wdata, 0);
      chk({tag, "_cpu_rst"}, cpu_rst, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_words"}, words_loaded, 0);
   endtask

   task automatic check_result(input string tag, input int exp_done, input int exp_err,
                               input int exp_words);
      @(negedge clk);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_cpu_rst"}, cpu_rst, exp_done ? 0 : 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_words"}, words_loaded, exp_words);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      words[0] = 16'h1234;
      words[1] = 16'hABCD;
      words[2] = 16'h0001;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_values("reset");

      // Normal load: 00 03 12 34 AB CD 00 01, CHK = 0x42.
      pulse_start();
      send_frame(3, 0, 1'b0, -1, -1);
      check_result("normal", 1, 0, 3);
      chk("normal_im_addr", im_addr, 3);

      // Restart from DONE re-asserts core reset and clears status.
      pulse_start();
      @(negedge clk);
      chk("restart_done", done, 0);
      chk("restart_cpu_rst", cpu_rst, 1);
      chk("restart_in_ready", in_ready, 1);
      chk("restart_words", words_loaded, 0);
      send_frame(3, 0, 1'b1, -1, -1);
      check_result("badchk", 0, 2, 3);

      // Length overflow: N = 1025.
      pulse_start();
      @(negedge clk);
      chk("errclr_err", err, 0);
      send_byte(8'h04, 0, 1'b0, 1'b0);
      send_byte(8'h01, 0, 1'b0, 1'b0);
      check_result("lenovf", 0, 1, 0);
      repeat (3) @(negedge clk);
      chk("lenovf_hold_err", err, 1);

      // Zero length: 00 00 00.
      pulse_start();
      send_frame(0, 0, 1'b0, -1, -1);
      check_result("zero", 1, 0, 0);

      // Irregular gaps plus an ignored start pulse mid-frame.
      pulse_start();
      send_frame(3, 3, 1'b0, 4, -1);
      check_result("gaps", 1, 0, 3);

      // Reset coincident with acceptance of word 1's low byte.
      pulse_start();
      send_frame(3, 0, 1'b0, -1, 5);
      check_reset_values("midrst");
      repeat (3) @(negedge clk);
      chk("midrst_sb_empty", sb.size(), 0);
      pulse_start();
      send_frame(3, 0, 1'b0, -1, -1);
      check_result("reload", 1, 0, 3);

      // Full-capacity load: N = 1024, address wraps to 0 afterwards.
      for (int i = 0; i < 1024; i++) words[i] = 16'(i * 7) ^ 16'h5A3C;
      pulse_start();
      send_frame(1024, 0, 1'b0, -1, -1);
      check_result("full", 1, 0, 1024);
      chk("full_im_addr_wrap", im_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
